ntt_butterfly_unit: RTL

//  Pipelined radix-2 butterfly for the 12-bit NTT/INTT datapath (q = 3329).

---
 rtl/ntt_butterfly_unit_pkg.sv | 42 ++++
 rtl/modular_mul.sv | 69 ++++++
 rtl/ntt_butterfly_unit_bf_delay_line.sv | 38 +++
 rtl/ntt_butterfly_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/ntt_butterfly_unit_pkg.sv
// Shared constants, mode encoding and modular add/sub helpers for the
// q = 3329 NTT/INTT butterfly datapath.
package ntt_butterfly_unit_pkg;

  localparam int BF_DATA_WIDTH = 12;
  localparam int BF_Q          = 3329;
  localparam int BF_MUL_LAT    = 4;

  localparam logic [BF_DATA_WIDTH-1:0] BF_Q_W = BF_DATA_WIDTH'(BF_Q);

  typedef enum logic {
    BF_CT = 1'b0,
    BF_GS = 1'b1
  } bf_mode_e;

  // (x + y) mod Q for x, y < Q: one conditional subtract is enough.
  function automatic logic [BF_DATA_WIDTH-1:0] mod_add(
    input logic [BF_DATA_WIDTH-1:0] x,
    input logic [BF_DATA_WIDTH-1:0] y
  );
    logic [BF_DATA_WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, BF_Q_W}) begin
      s = s - {1'b0, BF_Q_W};
    end
    return s[BF_DATA_WIDTH-1:0];
  endfunction

  // (x - y) mod Q for x, y < Q: the extra MSB is the borrow flag.
  function automatic logic [BF_DATA_WIDTH-1:0] mod_sub(
    input logic [BF_DATA_WIDTH-1:0] x,
    input logic [BF_DATA_WIDTH-1:0] y
  );
    logic [BF_DATA_WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[BF_DATA_WIDTH]) begin
      d = d + {1'b0, BF_Q_W};
    end
    return d[BF_DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/modular_mul.sv
// Fixed-modulus (q = 3329) modular multiplier, 4-cycle latency, Barrett
// reduction with k = 24 so every 12-bit x 12-bit product is covered.
module modular_mul
  import ntt_butterfly_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BF_DATA_WIDTH-1:0] a,
  input  logic [BF_DATA_WIDTH-1:0] b,
  output logic [BF_DATA_WIDTH-1:0] p
);

  localparam int PROD_W    = 2 * BF_DATA_WIDTH;
  localparam int BARRETT_M = (1 << PROD_W) / BF_Q;
  localparam int EST_W     = 13;
  localparam int REM_W     = 14;
  localparam int WIDE_W    = PROD_W + EST_W;

  localparam logic [REM_W-1:0] Q_R  = REM_W'(BF_Q);
  localparam logic [REM_W-1:0] Q2_R = REM_W'(2 * BF_Q);

  // The Barrett estimate undershoots by at most 2, so the remainder is < 3Q.
  function automatic logic [BF_DATA_WIDTH-1:0] reduce_3q(input logic [REM_W-1:0] r);
    logic [REM_W-1:0] t;
    if (r >= Q2_R) begin
      t = r - Q2_R;
    end else if (r >= Q_R) begin
      t = r - Q_R;
    end else begin
      t = r;
    end
    return BF_DATA_WIDTH'(t);
  endfunction

  logic [PROD_W-1:0] prod_p1;
  logic [REM_W-1:0]  prod_lo_p2;
  logic [EST_W-1:0]  qest_p2;
  logic [REM_W-1:0]  rem_p3;

  logic [EST_W-1:0]  qest;
  logic [REM_W-1:0]  qq_lo;

  // The true remainder fits in REM_W bits, so only the low bits of the
  // product and of qest*Q are needed for the subtraction.
  assign qest  = EST_W'((WIDE_W'(prod_p1) * WIDE_W'(BARRETT_M)) >> PROD_W);
  assign qq_lo = REM_W'({1'b0, qest_p2} * Q_R);

  // Four-stage multiply / estimate / subtract / correct pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_p1    <= '0;
      prod_lo_p2 <= '0;
      qest_p2    <= '0;
      rem_p3     <= '0;
      p          <= '0;
    end else begin
      // Stage 1: full product
      prod_p1    <= {{BF_DATA_WIDTH{1'b0}}, a} * {{BF_DATA_WIDTH{1'b0}}, b};
      // Stage 2: quotient estimate
      prod_lo_p2 <= prod_p1[REM_W-1:0];
      qest_p2    <= qest;
      // Stage 3: coarse remainder
      rem_p3     <= prod_lo_p2 - qq_lo;
      // Stage 4: final correction
      p          <= reduce_3q(rem_p3);
    end
  end

endmodule

// File: rtl/ntt_butterfly_unit_bf_delay_line.sv
// DEPTH x WIDTH shift register with synchronous reset. The MSB of each word
// is treated as an occupancy flag and OR-reduced over all stages on live.
module bf_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             live
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  // Shift one stage per clock; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[DEPTH-1];

  // Any stage holding a flagged word.
  always_comb begin
    live = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      live = live | pipe[i][WIDTH-1];
    end
  end

endmodule

// File: rtl/ntt_butterfly_unit.sv
// Pipelined radix-2 NTT/INTT butterfly (q = 3329), 6-cycle latency, one
// sample per clock. Mode per sample: CT (forward) or GS (inverse).
module ntt_butterfly_unit
  import ntt_butterfly_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  busy
);

  // The multiplier has a fixed modulus, width and latency.
  if (Q != BF_Q || DATA_WIDTH != BF_DATA_WIDTH || MUL_LAT != BF_MUL_LAT) begin : g_param_check
    $error("ntt_butterfly_unit: Q, DATA_WIDTH and MUL_LAT must match modular_mul");
  end

  localparam int DL_W = DATA_WIDTH + 2;

  logic                  vld_p1;
  logic                  mode_p1;
  logic [DATA_WIDTH-1:0] x_p1;
  logic [DATA_WIDTH-1:0] op_p1;
  logic [DATA_WIDTH-1:0] w_p1;

  logic                  vld_p5;
  logic                  mode_p5;
  logic [DATA_WIDTH-1:0] x_p5;
  logic [DATA_WIDTH-1:0] p_p5;

  logic [DL_W-1:0]       dl_dout;
  logic                  dl_live;

  // Stage 1: choose multiplier operand and bypass operand by mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      mode_p1 <= 1'b0;
      x_p1    <= '0;
      op_p1   <= '0;
      w_p1    <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        mode_p1 <= mode;
        w_p1    <= w_in;
        if (mode == BF_GS) begin
          op_p1 <= mod_sub(a_in, b_in);
          x_p1  <= mod_add(a_in, b_in);
        end else begin
          op_p1 <= b_in;
          x_p1  <= a_in;
        end
      end else begin
        mode_p1 <= 1'b0;
        w_p1    <= '0;
        op_p1   <= '0;
        x_p1    <= '0;
      end
    end
  end

  // Stages 2-5: product and matching delay of x / mode / valid.
  modular_mul u_mul (
    .clk (clk),
    .rst (rst),
    .a   (op_p1),
    .b   (w_p1),
    .p   (p_p5)
  );

  bf_delay_line #(
    .DEPTH (MUL_LAT),
    .WIDTH (DL_W)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({vld_p1, mode_p1, x_p1}),
    .dout (dl_dout),
    .live (dl_live)
  );

  assign vld_p5  = dl_dout[DL_W-1];
  assign mode_p5 = dl_dout[DL_W-2];
  assign x_p5    = dl_dout[DATA_WIDTH-1:0];

  // Stage 6: final add/sub for CT, pass-through for GS; hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
    end else begin
      out_valid <= vld_p5;
      if (vld_p5) begin
        if (mode_p5 == BF_GS) begin
          a_out <= x_p5;
          b_out <= p_p5;
        end else begin
          a_out <= mod_add(x_p5, p_p5);
          b_out <= mod_sub(x_p5, p_p5);
        end
      end
    end
  end

  assign busy = vld_p1 | dl_live | out_valid;

endmodule
